// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port pixel frame-buffer RAM between VGA
// scanout (show-ahead prefetch FIFO, sequential reads) and a pixel writer.
// Ports:
//   clock, res           - clock, asynchronous active-high reset
//   frame_start          - flush prefetch and restart scanout at address 0
//   pix_pop              - display consumes the head pixel
//   pix_data, pix_valid  - FIFO head pixel and non-empty flag
//   underflow            - sticky, pop while empty (cleared by frame_start)
//   wr_valid/addr/data   - writer request; wr_ready accepts it this cycle
//   mem_en/we/addr/wdata - registered RAM command port
//   mem_rdata            - RAM read data, one cycle after the sampling edge
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FB_PIXELS  = 76800,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WATER  = 4
) (
  input  logic              clock,
  input  logic              res,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LVL_W = CNT_W + 1;

  typedef enum logic {
    ST_REFILL = 1'b0,
    ST_SERVE  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] pix_data_next;
  logic [ADDR_W-1:0] rd_addr;
  logic              pipe_v1;
  logic              pipe_v2;
  logic [LVL_W-1:0]  level;
  logic              rd_issue;
  logic              wr_fire;
  logic              push;
  logic              pop_ok;
  logic              remain_zero;

  // Occupancy including reads still in flight; bounds issue so the FIFO never overflows.
  assign level  = LVL_W'(count) + LVL_W'(pipe_v1) + LVL_W'(pipe_v2);
  assign push   = pipe_v2 && !frame_start;
  assign pop_ok = pix_pop && (count != '0) && !frame_start;
  assign wr_fire = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      state <= ST_REFILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; frame_start always forces a refill
  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = ST_REFILL;
    end else begin
      case (state)
        ST_REFILL: if (level >= LVL_W'(FIFO_DEPTH)) state_next = ST_SERVE;
        ST_SERVE:  if (level <= LVL_W'(LOW_WATER))  state_next = ST_REFILL;
        default:   state_next = ST_REFILL;
      endcase
    end
  end

  // Slot allocation: reads while refilling, writer handshake while serving
  always_comb begin
    rd_issue = 1'b0;
    wr_ready = 1'b0;
    case (state)
      ST_REFILL: rd_issue = !frame_start && (level < LVL_W'(FIFO_DEPTH));
      ST_SERVE:  wr_ready = !frame_start;
      default:   ;
    endcase
  end

  // RAM command port; address and data hold on idle cycles
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= rd_issue || wr_fire;
      mem_we <= wr_fire;
      if (rd_issue) begin
        mem_addr <= rd_addr;
      end else if (wr_fire) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  // Scan address and read-return tracking; frame_start drops in-flight reads
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      rd_addr <= '0;
      pipe_v1 <= 1'b0;
      pipe_v2 <= 1'b0;
    end else if (frame_start) begin
      rd_addr <= '0;
      pipe_v1 <= 1'b0;
      pipe_v2 <= 1'b0;
    end else begin
      pipe_v1 <= rd_issue;
      pipe_v2 <= pipe_v1;
      if (rd_issue) begin
        rd_addr <= (rd_addr == ADDR_W'(FB_PIXELS - 1)) ? '0 : rd_addr + ADDR_W'(1);
      end
    end
  end

  // Next FIFO occupancy and registered show-ahead head
  always_comb begin
    remain_zero   = (count == CNT_W'(pop_ok));
    count_next    = count + CNT_W'(push) - CNT_W'(pop_ok);
    rd_ptr_next   = rd_ptr + PTR_W'(pop_ok);
    pix_data_next = pix_data;
    if (frame_start) begin
      count_next  = '0;
      rd_ptr_next = '0;
    end else if (count_next != '0) begin
      // A push into a FIFO that is (or becomes) empty bypasses the storage array.
      pix_data_next = (push && remain_zero) ? mem_rdata : fifo_mem[rd_ptr_next];
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  // FIFO pointers, head register and status flags
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= frame_start ? '0 : wr_ptr + PTR_W'(push);
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      pix_data  <= pix_data_next;
      pix_valid <= (count_next != '0);
      if (frame_start) begin
        underflow <= 1'b0;
      end else if (pix_pop && (count == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed scenarios plus randomized pops and
// writes, checked against a transaction-level model (read-order queue with
// arrival times, RAM array, sticky underflow flag).
module tb_vga_fb_arbiter;

  localparam int FB = 64;

  logic        clock;
  logic        res;
  logic        frame_start;
  logic        pix_pop;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        underflow;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  logic [11:0] ram [131072];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q_addr[$];
  int q_arr[$];
  int exp_rd_addr;
  logic exp_uf;
  logic rd_seen;
  int   rd_seen_addr;

  vga_fb_arbiter #(.FB_PIXELS(FB)) dut (
    .clock(clock), .res(res), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with one cycle read latency
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_arr.delete();
    exp_rd_addr = 0;
    exp_uf      = 1'b0;
  endtask

  task automatic wr_rand();
    wr_addr = 17'(100 + $urandom_range(0, 60000));
    wr_data = 12'($urandom);
  endtask

  // One clock with the currently driven inputs, checking the model before and after the edge
  task automatic step();
    logic s_fs, s_pop, s_acc;
    logic [16:0] s_wa;
    logic [11:0] s_wd;
    int avail;
    @(negedge clock);
    s_fs  = frame_start;
    s_pop = pix_pop;
    s_acc = wr_valid && wr_ready;
    s_wa  = wr_addr;
    s_wd  = wr_data;
    avail = 0;
    foreach (q_arr[i]) if (q_arr[i] <= cyc) avail++;
    check("pix_valid", 32'(pix_valid), 32'(avail > 0));
    if (avail > 0) check("pix_data_head", 32'(pix_data), 32'(ram[q_addr[0]]));
    if (s_fs) check("fs_wr_ready", 32'(wr_ready), 32'd0);
    if (s_pop && !s_fs) begin
      if (avail > 0) begin
        void'(q_addr.pop_front());
        void'(q_arr.pop_front());
      end else begin
        exp_uf = 1'b1;
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    rd_seen = 1'b0;
    if (s_fs) begin
      q_addr.delete();
      q_arr.delete();
      exp_rd_addr = 0;
      exp_uf      = 1'b0;
      check("fs_idle", 32'(mem_en), 32'd0);
    end else if (s_acc) begin
      check("wr_en", 32'(mem_en), 32'd1);
      check("wr_we", 32'(mem_we), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'(s_wa));
      check("wr_wdata", 32'(mem_wdata), 32'(s_wd));
    end else if (mem_en) begin
      check("rd_we", 32'(mem_we), 32'd0);
      check("rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
      rd_seen      = 1'b1;
      rd_seen_addr = int'(mem_addr);
      q_addr.push_back(exp_rd_addr);
      q_arr.push_back(cyc + 2);
      exp_rd_addr = (exp_rd_addr + 1) % FB;
    end
    check("underflow", 32'(underflow), 32'(exp_uf));
  endtask

  task automatic do_reset();
    frame_start = 1'b0;
    pix_pop     = 1'b0;
    wr_valid    = 1'b0;
    #2 res = 1'b1;
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1 res = 1'b0;
    model_reset();
  endtask

  initial begin
    int nrd, first_rd, last_rd, prev_rd, pd, k;
    logic saw_wrap;
    res = 1'b1;
    frame_start = 1'b0;
    pix_pop = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 131072; i++) ram[i] = 12'(i);
    model_reset();
    @(posedge clock);
    do_reset();

    // Prefetch after reset: eight consecutive reads, then serving
    nrd = 0; first_rd = -1; last_rd = -1;
    repeat (20) begin
      step();
      if (rd_seen) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        nrd++;
      end
    end
    check("t1_reads", 32'(nrd), 32'd8);
    check("t1_consecutive", 32'(last_rd - first_rd), 32'd7);
    check("t1_pix_data", 32'(pix_data), 32'd0);
    check("t1_pix_valid", 32'(pix_valid), 32'd1);
    check("t1_serve", 32'(wr_ready), 32'd1);

    // Single write in SERVE
    wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 12'habc;
    #1 check("t2_wr_ready", 32'(wr_ready), 32'd1);
    step();
    check("t2_mem_en", 32'(mem_en), 32'd1);
    check("t2_mem_we", 32'(mem_we), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'd100);
    check("t2_mem_wdata", 32'(mem_wdata), 32'habc);

    // Four pops every 4th cycle with a waiting writer; level 4 triggers refill
    for (int p = 0; p < 4; p++) begin
      wr_rand(); pix_pop = 1'b1;
      step();
      pix_pop = 1'b0;
      if (p < 3) repeat (3) begin wr_rand(); step(); end
    end
    wr_rand();
    step();
    check("t3_refill_wr_ready", 32'(wr_ready), 32'd0);
    nrd = 0; first_rd = -1;
    repeat (10) begin
      wr_rand();
      step();
      if (rd_seen) begin
        if (first_rd < 0) first_rd = rd_seen_addr;
        nrd++;
      end
    end
    check("t3_reads", 32'(nrd), 32'd4);
    check("t3_first_addr", 32'(first_rd), 32'd8);
    check("t3_serve_back", 32'(wr_ready), 32'd1);

    // Random pops and writes across the end-of-frame wrap
    saw_wrap = 1'b0; prev_rd = -1;
    repeat (75) begin
      wr_valid = 1'($urandom); wr_rand(); pix_pop = 1'b1;
      step();
      pix_pop = 1'b0;
      if (rd_seen) begin
        if (prev_rd == FB - 1 && rd_seen_addr == 0) saw_wrap = 1'b1;
        prev_rd = rd_seen_addr;
      end
      repeat ($urandom_range(1, 4)) begin
        wr_valid = 1'($urandom); wr_rand();
        step();
        if (rd_seen) begin
          if (prev_rd == FB - 1 && rd_seen_addr == 0) saw_wrap = 1'b1;
          prev_rd = rd_seen_addr;
        end
      end
    end
    check("t4_wrap", 32'(saw_wrap), 32'd1);
    wr_valid = 1'b0;

    // Underflow on an empty FIFO after a held frame_start
    frame_start = 1'b1;
    repeat (3) step();
    frame_start = 1'b0;
    pd = int'(pix_data);
    pix_pop = 1'b1;
    step();
    pix_pop = 1'b0;
    check("t5_underflow", 32'(underflow), 32'd1);
    check("t5_pix_hold", 32'(pix_data), 32'(pd));
    k = 0;
    while (k < 20 && !pix_valid) begin step(); k++; end
    check("t5_refilled", 32'(pix_valid), 32'd1);
    check("t5_first_pix", 32'(pix_data), 32'(ram[0]));
    wr_valid = 1'b1; wr_rand();
    #1;
    k = 0;
    while (k < 20 && !wr_ready) begin step(); wr_rand(); #1; k++; end
    check("t5_serve", 32'(wr_ready), 32'd1);
    frame_start = 1'b1;
    #1 check("t5_fs_wr_ready", 32'(wr_ready), 32'd0);
    step();
    frame_start = 1'b0;
    wr_valid = 1'b0;
    check("t5_uf_cleared", 32'(underflow), 32'd0);

    // frame_start one cycle after the read of address 5 is issued
    k = 0; rd_seen = 1'b0;
    while (k < 12 && !(rd_seen && rd_seen_addr == 5)) begin step(); k++; end
    check("t6_saw_addr5", 32'(rd_seen && rd_seen_addr == 5), 32'd1);
    frame_start = 1'b1; wr_valid = 1'b1; wr_rand();
    #1 check("t6_fs_wr_ready", 32'(wr_ready), 32'd0);
    step();
    frame_start = 1'b0; wr_valid = 1'b0;
    step();
    check("t6_restart_en", 32'(mem_en), 32'd1);
    check("t6_restart_addr", 32'(mem_addr), 32'd0);
    step();
    check("t6_not_yet_valid", 32'(pix_valid), 32'd0);
    step();
    check("t6_valid_latency", 32'(pix_valid), 32'd1);
    check("t6_first_pix", 32'(pix_data), 32'(ram[0]));

    // Mid-operation reset, then a fresh prefetch
    repeat (10) begin
      pix_pop = 1'($urandom) & ~pix_pop;
      step();
    end
    pix_pop = 1'b0;
    do_reset();
    nrd = 0;
    repeat (16) begin
      step();
      if (rd_seen) nrd++;
    end
    check("t7_reads", 32'(nrd), 32'd8);
    check("t7_pix_data", 32'(pix_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
